// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch_pc program-counter / instruction-fetch stage.
package fetch_pkg;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and instruction memory (slave).
interface fetch_pc_if #(
    parameter int W = 32
);
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_pc_next.sv
// Combinational next-PC selection: branch target or sequential step, plus target misalignment bit.
module pc_next
    import fetch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] pc,
    input  logic [W-1:0] ImmOp,
    input  logic         PCsrc,
    output logic [W-1:0] next_pc,
    output logic         target_misalign
);

    logic [W-1:0] target;

    // Both adds wrap modulo 2^W; a negative offset is simply two's complement.
    assign target          = pc + ImmOp;
    assign next_pc         = PCsrc ? target : pc + W'(PC_STEP);
    assign target_misalign = |target[1:0];

endmodule

// File: rtl/fetch_pc.sv
// Program counter and instruction-fetch FSM (FETCH / ISSUE / HALT).
// Optional macro FETCH_MISALIGN_CHECK_EN halts on a misaligned branch target.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = W'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCsrc,
    input  logic [W-1:0]  ImmOp,
    input  logic          stall,
    fetch_pc_if.master    imem,
    output logic [W-1:0]  instr,
    output logic          instr_valid,
    output logic [W-1:0]  pc,
    output logic [W-1:0]  icount,
    output logic          misalign
);

    fetch_state_t state_reg;
    logic [W-1:0] pc_reg;
    logic [W-1:0] instr_reg;
    logic [W-1:0] icount_reg;
    logic         valid_reg;
    logic         req_reg;
    logic [W-1:0] pc_next_val;
    logic         target_misalign;

    pc_next #(.W(W)) u_pc_next (
        .pc              (pc_reg),
        .ImmOp           (ImmOp),
        .PCsrc           (PCsrc),
        .next_pc         (pc_next_val),
        .target_misalign (target_misalign)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_reg;
    assign misalign = misalign_reg;
`else
    logic unused_misalign;
    assign unused_misalign = target_misalign;
    assign misalign        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            instr_reg  <= '0;
            icount_reg <= '0;
            valid_reg  <= 1'b0;
            req_reg    <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr_reg <= imem.imem_rdata;
                        valid_reg <= 1'b1;
                        req_reg   <= 1'b0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (PCsrc && target_misalign) begin
                            misalign_reg <= 1'b1;
                            valid_reg    <= 1'b0;
                            state_reg    <= HALT;
                        end else
`endif
                        begin
                            pc_reg     <= pc_next_val;
                            icount_reg <= icount_reg + W'(1);
                            valid_reg  <= 1'b0;
                            req_reg    <= 1'b1;
                            state_reg  <= FETCH;
                        end
                    end
                end
                HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    state_reg <= FETCH;
                    valid_reg <= 1'b0;
                    req_reg   <= 1'b1;
                end
            endcase
        end
    end

    // Request is suppressed combinationally while reset is asserted.
    assign imem.imem_req  = req_reg & ~rst;
    assign imem.imem_addr = pc_reg;
    assign instr          = instr_reg;
    assign instr_valid    = valid_reg;
    assign pc             = pc_reg;
    assign icount         = icount_reg;

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter and instruction-fetch stage sitting directly upstream of the instruction decoder/control unit. It holds the PC, requests each instruction word from instruction memory over a req/ack handshake, and presents the captured word as `instr` for decode. It samples the decoder's `PCsrc` together with the branch offset `ImmOp` to select the next PC. A retired-instruction counter is maintained for debug.

## Interface
- `W`, 32: data and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `PCsrc`  in  1  from control: 1 = take branch/jump target.
- `ImmOp`  in  W  sign-extended offset from the immediate unit.
- `stall`  in  1  hold the current instruction in ISSUE.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  W  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  W  instruction word.
- `instr`  out  W  registered instruction to decode.
- `instr_valid`  out  1  `instr` is valid (ISSUE state).
- `pc`  out  W  current PC.
- `icount`  out  W  instructions retired.
- `misalign`  out  1  misaligned-target halt flag.

## Operation
- States: FETCH, ISSUE, HALT.
- Reset values: state FETCH; `pc`=`RESET_PC`; `instr`=0; `instr_valid`=0; `icount`=0; `misalign`=0. `imem_req`=0 in any cycle where `rst`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `instr` <= `imem_rdata`, then go to ISSUE.
  - Otherwise stay in FETCH with the request held and the address stable.
- ISSUE:
  - `instr_valid`=1, `imem_req`=0.
  - If `stall`=1: stay; `instr`, `pc` and `icount` hold.
  - If `stall`=0: `pc` <= `PCsrc` ? `pc`+`ImmOp` : `pc`+4; `icount` <= `icount`+1; go to FETCH.
- `PCsrc` and `ImmOp` are sampled only in ISSUE with `stall`=0; they are don't-care elsewhere.
- `imem_ack` outside FETCH is ignored; `imem_rdata` is never captured outside FETCH.
- Arithmetic:
  - All adds are modulo 2^W. `pc`=32'hFFFF_FFFC with no branch wraps to 0.
  - A negative `ImmOp` wraps naturally.
  - `icount` wraps from all-ones to 0.
- HALT: entered only with the configuration feature enabled. `imem_req`=0, `instr_valid`=0, and `pc`/`icount` frozen. Exit only by `rst`.
- Reset mid-operation: `rst` overrides everything in the same edge. An outstanding fetch is abandoned, and a late ack after reset is taken as the ack of the new FETCH at `RESET_PC`.

## Timing
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then ISSUE.
- Each memory wait cycle adds 1; each stall cycle adds 1.
- `instr` and `instr_valid` are registered and valid the cycle after the ack.
- `pc` updates on the ISSUE→FETCH edge, so `imem_addr` shows the new PC in the first FETCH cycle.
- Decode of `instr` into `PCsrc` is combinational within the ISSUE cycle.

## Configuration
- Macro: `FETCH_MISALIGN_CHECK_EN`.
- Defined:
  - In ISSUE with `stall`=0 and `PCsrc`=1, if (`pc`+`ImmOp`)[1:0] != 0: `pc` is not updated, `icount` is not incremented, `misalign` <= 1, and the state goes to HALT.
  - A sequential `pc`+4 step is never checked.
- Undefined: the target is taken unchanged, HALT is unreachable, and `misalign` is tied to 0.

## Structure
- Shared package `fetch_pkg`:
  - state enum typedef `fetch_state_t` (FETCH, ISSUE, HALT);
  - constant `PC_STEP` = 4;
  - default `RESET_PC`.
- One combinational sub-module, `pc_next`: inputs `pc`, `ImmOp`, `PCsrc`; outputs the next PC and the target misalignment bit. It is instantiated once.

## Test plan
- Reset then ack in every FETCH; `imem_rdata`=32'h0000_0013 each time; `PCsrc`=0 → `imem_addr` sequence 0,4,8,C on every other cycle; `icount`=4 after 8 cycles.
- In ISSUE at `pc`=8, `PCsrc`=1 and `ImmOp`=32'hFFFF_FFF8 → next `imem_addr`=0; `icount` increments.
- Delay ack by 3 cycles, and hold `stall`=1 for 2 ISSUE cycles → `imem_req` is high for 4 cycles with a stable address, and `instr` is unchanged during the stall.
- `RESET_PC`=32'hFFFF_FFFC, no branch → the second fetch address is 0.
- Assert `rst` during a pending FETCH, then give an ack one cycle after reset → captured `instr` is the word for `RESET_PC` and `icount`=0.
- With `FETCH_MISALIGN_CHECK_EN`, `pc`=4, `PCsrc`=1, `ImmOp`=2:
  - `misalign`=1 next cycle, `imem_req` stays 0, and `pc` remains 4 until reset.
  - Without the macro the next `imem_addr`=6.
